// File: rtl/regfile_pkg.sv
// Shared widths and state encoding for the register-file write scheduler.
package regfile_pkg;

  function automatic int CeilLog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  localparam int WORD_LENGTH = 32;
  localparam int NBITS       = CeilLog2(WORD_LENGTH);

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-requester round-robin arbiter with a last-grant pointer.
module rr_arbiter_2 (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0,
  input  logic       req1,
  input  logic       advance,
  output logic [1:0] grant
);

  // last = index of the most recent accepted winner; 1 after reset so requester 0 wins the first tie
  logic last;

  always_comb begin
    grant = 2'b00;
    if (req0 && req1) begin
      grant = last ? 2'b01 : 2'b10;
    end else if (req0) begin
      grant = 2'b01;
    end else if (req1) begin
      grant = 2'b10;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last <= 1'b1;
    end else if (advance && (grant != 2'b00)) begin
      last <= grant[1];
    end
  end

endmodule

// File: rtl/regfile_write_scheduler.sv
// Owns the register-file write port: clear sweep after reset or on request,
// then round-robin sharing between ALU (0) and load (1) writebacks.
module regfile_write_scheduler
  import regfile_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear_req,
  input  logic                   valid0,
  input  logic [NBITS-1:0]       addr0,
  input  logic [WORD_LENGTH-1:0] data0,
  output logic                   ready0,
  input  logic                   valid1,
  input  logic [NBITS-1:0]       addr1,
  input  logic [WORD_LENGTH-1:0] data1,
  output logic                   ready1,
  output logic                   init_done,
  output logic                   Write,
  output logic [NBITS-1:0]       Write_Reg,
  output logic [WORD_LENGTH-1:0] Write_Data,
  output logic                   fsm_state
);

  // Handshake: a transfer happens in a cycle where valid and ready are both high;
  // requesters hold valid/addr/data until ready, and may withdraw valid freely.

  state_t           state;
  logic [NBITS-1:0] cnt;
  logic             accept_en;
  logic [1:0]       grant;
  logic             xfer;
  logic [NBITS-1:0] xfer_addr;
  logic [WORD_LENGTH-1:0] xfer_data;

  assign accept_en = (state == RUN) && !clear_req;

  rr_arbiter_2 u_arb (
    .clk     (clk),
    .reset   (reset),
    .req0    (valid0 && accept_en),
    .req1    (valid1 && accept_en),
    .advance (xfer),
    .grant   (grant)
  );

  assign ready0    = grant[0];
  assign ready1    = grant[1];
  assign xfer      = ready0 || ready1;
  assign xfer_addr = ready1 ? addr1 : addr0;
  assign xfer_data = ready1 ? data1 : data0;
  assign fsm_state = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= CLEAR;
      cnt        <= '0;
      init_done  <= 1'b0;
      Write      <= 1'b0;
      Write_Reg  <= '0;
      Write_Data <= '0;
    end else begin
      case (state)
        CLEAR: begin
          Write      <= 1'b1;
          Write_Reg  <= cnt;
          Write_Data <= '0;
          cnt        <= cnt + 1'b1;
          if (cnt == NBITS'(WORD_LENGTH - 1)) begin
            state     <= RUN;
            init_done <= 1'b1;
          end
        end
        RUN: begin
          if (clear_req) begin
            state     <= CLEAR;
            cnt       <= '0;
            init_done <= 1'b0;
            Write     <= 1'b0;
          end else if (xfer) begin
            // $zero is hard-wired: the transfer is consumed but never reaches the file
            Write <= (xfer_addr != '0);
            if (xfer_addr != '0) begin
              Write_Reg  <= xfer_addr;
              Write_Data <= xfer_data;
            end
          end else begin
            Write <= 1'b0;
          end
        end
        default: begin
          state <= CLEAR;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Directed bench for regfile_write_scheduler: sweep, arbitration, addr-0, clear and reset.
module tb_regfile_write_scheduler;
  import regfile_pkg::*;

  logic                   clk;
  logic                   reset;
  logic                   clear_req;
  logic                   valid0;
  logic [NBITS-1:0]       addr0;
  logic [WORD_LENGTH-1:0] data0;
  logic                   ready0;
  logic                   valid1;
  logic [NBITS-1:0]       addr1;
  logic [WORD_LENGTH-1:0] data1;
  logic                   ready1;
  logic                   init_done;
  logic                   Write;
  logic [NBITS-1:0]       Write_Reg;
  logic [WORD_LENGTH-1:0] Write_Data;
  logic                   fsm_state;

  int n_cmp;
  int n_err;

  regfile_write_scheduler dut (
    .clk        (clk),
    .reset      (reset),
    .clear_req  (clear_req),
    .valid0     (valid0),
    .addr0      (addr0),
    .data0      (data0),
    .ready0     (ready0),
    .valid1     (valid1),
    .addr1      (addr1),
    .data1      (data1),
    .ready1     (ready1),
    .init_done  (init_done),
    .Write      (Write),
    .Write_Reg  (Write_Reg),
    .Write_Data (Write_Data),
    .fsm_state  (fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance one edge and land 1ns after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // 32 sweep edges from CLEAR entry; checks the write port and the held-off ready lines
  task automatic check_sweep(input string tag);
    for (int i = 0; i < 32; i++) begin
      #1;
      n_cmp++;
      if (ready0 !== 1'b0 || ready1 !== 1'b0) begin
        n_err++;
        $display("FAIL %s_ready idx=%0d got r0=%b r1=%b want 0 0", tag, i, ready0, ready1);
      end
      tick();
      n_cmp++;
      if (Write !== 1'b1 || Write_Reg !== NBITS'(i) || Write_Data !== '0) begin
        n_err++;
        $display("FAIL %s_write idx=%0d got W=%b reg=%0d data=%h want W=1 reg=%0d data=0",
                 tag, i, Write, Write_Reg, Write_Data, i);
      end
      n_cmp++;
      if (init_done !== (i == 31)) begin
        n_err++;
        $display("FAIL %s_init_done idx=%0d got %b want %b", tag, i, init_done, (i == 31));
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; clear_req = 1'b0;
    valid0 = 1'b0; addr0 = '0; data0 = '0;
    valid1 = 1'b0; addr1 = '0; data1 = '0;
    tick(); tick();
    n_cmp++;
    if (Write !== 1'b0 || Write_Reg !== '0 || Write_Data !== '0 || init_done !== 1'b0 ||
        ready0 !== 1'b0 || ready1 !== 1'b0 || fsm_state !== 1'b0) begin
      n_err++;
      $display("FAIL reset_values got W=%b reg=%0d data=%h init=%b r0=%b r1=%b st=%b want all 0",
               Write, Write_Reg, Write_Data, init_done, ready0, ready1, fsm_state);
    end
    reset = 1'b1;
    check_sweep("sweep");
  endtask

  task automatic test_back_to_back();
    int exp_port [4] = '{0, 1, 0, 1};
    logic [NBITS-1:0] exp_addr [4] = '{5'd5, 5'd4, 5'd5, 5'd4};
    logic [WORD_LENGTH-1:0] exp_data [4] = '{32'hFEFEFEFE, 32'hABABABAB, 32'hFEFEFEFE, 32'hABABABAB};
    int cnt0, cnt1;
    cnt0 = 0; cnt1 = 0;
    valid0 = 1'b1; addr0 = 5'd5; data0 = 32'hFEFEFEFE;
    valid1 = 1'b1; addr1 = 5'd4; data1 = 32'hABABABAB;
    for (int k = 0; k < 4; k++) begin
      #1;
      n_cmp++;
      if (ready0 !== (exp_port[k] == 0) || ready1 !== (exp_port[k] == 1)) begin
        n_err++;
        $display("FAIL b2b_grant k=%0d got r0=%b r1=%b want port %0d", k, ready0, ready1, exp_port[k]);
      end
      if (ready0) cnt0++;
      if (ready1) cnt1++;
      tick();
      if (cnt0 == 2) valid0 = 1'b0;
      if (cnt1 == 2) valid1 = 1'b0;
      n_cmp++;
      if (Write !== 1'b1 || Write_Reg !== exp_addr[k] || Write_Data !== exp_data[k]) begin
        n_err++;
        $display("FAIL b2b_write k=%0d got W=%b reg=%0d data=%h want W=1 reg=%0d data=%h",
                 k, Write, Write_Reg, Write_Data, exp_addr[k], exp_data[k]);
      end
    end
    tick();
    n_cmp++;
    if (Write !== 1'b0 || Write_Reg !== 5'd4 || Write_Data !== 32'hABABABAB) begin
      n_err++;
      $display("FAIL b2b_idle got W=%b reg=%0d data=%h want W=0 reg=4 data=abababab",
               Write, Write_Reg, Write_Data);
    end
  endtask

  task automatic test_addr_zero();
    // requester 0 alone first, so last points at 0 before the addr-0 transfer
    valid0 = 1'b1; addr0 = 5'd2; data0 = 32'h00000022;
    tick();
    valid0 = 1'b0;
    valid1 = 1'b1; addr1 = '0; data1 = 32'h12345678;
    #1;
    n_cmp++;
    if (ready1 !== 1'b1 || ready0 !== 1'b0) begin
      n_err++;
      $display("FAIL addr0_ready got r0=%b r1=%b want r0=0 r1=1", ready0, ready1);
    end
    tick();
    valid1 = 1'b0;
    n_cmp++;
    if (Write !== 1'b0) begin
      n_err++;
      $display("FAIL addr0_suppress got W=%b want 0", Write);
    end
    valid0 = 1'b1; addr0 = 5'd7; data0 = 32'h11111111;
    valid1 = 1'b1; addr1 = 5'd9; data1 = 32'h22222222;
    #1;
    n_cmp++;
    if (ready0 !== 1'b1 || ready1 !== 1'b0) begin
      n_err++;
      $display("FAIL addr0_tie got r0=%b r1=%b want r0=1 r1=0", ready0, ready1);
    end
    tick();
    valid0 = 1'b0; valid1 = 1'b0;
    n_cmp++;
    if (Write !== 1'b1 || Write_Reg !== 5'd7 || Write_Data !== 32'h11111111) begin
      n_err++;
      $display("FAIL addr0_tie_write got W=%b reg=%0d data=%h want W=1 reg=7 data=11111111",
               Write, Write_Reg, Write_Data);
    end
  endtask

  task automatic test_clear_req();
    valid0 = 1'b1; addr0 = 5'd3; data0 = 32'hCAFEF00D;
    clear_req = 1'b1;
    #1;
    n_cmp++;
    if (ready0 !== 1'b0) begin
      n_err++;
      $display("FAIL clear_ready got %b want 0", ready0);
    end
    tick();
    clear_req = 1'b0;
    n_cmp++;
    if (init_done !== 1'b0 || Write !== 1'b0) begin
      n_err++;
      $display("FAIL clear_entry got init=%b W=%b want init=0 W=0", init_done, Write);
    end
    check_sweep("clear");
    #1;
    n_cmp++;
    if (ready0 !== 1'b1) begin
      n_err++;
      $display("FAIL clear_pending_ready got %b want 1", ready0);
    end
    tick();
    valid0 = 1'b0;
    n_cmp++;
    if (Write !== 1'b1 || Write_Reg !== 5'd3 || Write_Data !== 32'hCAFEF00D) begin
      n_err++;
      $display("FAIL clear_pending_write got W=%b reg=%0d data=%h want W=1 reg=3 data=cafef00d",
               Write, Write_Reg, Write_Data);
    end
  endtask

  task automatic test_reset_mid_sweep();
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    for (int i = 0; i < 18; i++) tick();
    n_cmp++;
    if (Write_Reg !== 5'd17) begin
      n_err++;
      $display("FAIL midreset_index got %0d want 17", Write_Reg);
    end
    reset = 1'b0;
    #1;
    n_cmp++;
    if (Write !== 1'b0 || Write_Reg !== '0 || Write_Data !== '0 || init_done !== 1'b0 ||
        fsm_state !== 1'b0) begin
      n_err++;
      $display("FAIL midreset_async got W=%b reg=%0d data=%h init=%b st=%b want all 0",
               Write, Write_Reg, Write_Data, init_done, fsm_state);
    end
    @(posedge clk);
    #2;
    n_cmp++;
    if (Write !== 1'b0 || Write_Reg !== '0) begin
      n_err++;
      $display("FAIL midreset_hold got W=%b reg=%0d want W=0 reg=0", Write, Write_Reg);
    end
    #1;
    reset = 1'b1;
    check_sweep("resweep");
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_back_to_back();
    test_addr_zero();
    test_clear_req();
    test_reset_mid_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_write_scheduler.md
# regfile_write_scheduler

Sequences and shares the single write port of `Register_File`. After every reset, and on request, it runs a clear sweep that writes zero to all registers. It then arbitrates two writeback requesters, ALU (port 0) and load (port 1), round-robin with valid/ready handshakes. It sits between the execute/memory writeback paths and the register file's `Write`/`Write_Reg`/`Write_Data` inputs.

## Interface
- `WORD_LENGTH`, 32, data width.
- `NBITS`, CeilLog2(WORD_LENGTH) = 5, register index width.

- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low.
- `clear_req` in 1: one-cycle pulse; starts a new clear sweep.
- `valid0` in 1: requester 0 (ALU) has a write.
- `addr0` in NBITS: requester 0 destination register.
- `data0` in WORD_LENGTH: requester 0 data.
- `ready0` out 1: requester 0 transfer accepted this cycle.
- `valid1`, `addr1`, `data1`, `ready1`: same set for requester 1 (load).
- `init_done` out 1: high while the block is in RUN.
- `Write` out 1: register-file write enable.
- `Write_Reg` out NBITS: register-file write index.
- `Write_Data` out WORD_LENGTH: register-file write data.

## Operation
- States: CLEAR and RUN. Reset enters CLEAR with sweep counter `cnt` = 0.
- CLEAR, each cycle:
  - Register `Write`=1, `Write_Reg`=`cnt`, `Write_Data`=0, then `cnt`++.
  - The edge that registers `cnt`=31 moves to RUN and sets `init_done`=1.
  - `ready0` and `ready1` are held at 0.
- RUN:
  - `ready0` and `ready1` are combinational: at most one is high, only when that requester's valid is high, and never while `clear_req`=1.
  - Arbitration uses last-grant pointer `last`. If both are valid, the requester ≠ `last` wins. If one is valid, it wins. `last` updates only on an accepted transfer.
  - An accepted transfer (valid&ready) registers `Write`=1, `Write_Reg`=addr, `Write_Data`=data at the next edge. With no transfer, `Write`=0 and `Write_Reg`/`Write_Data` hold their last values.
  - A transfer with addr = 0 is accepted (ready=1) but registers `Write`=0, because $zero is hard-wired. `last` still updates.
- `clear_req`=1 in RUN: the next edge enters CLEAR with `cnt`=0 and `init_done`=0. No transfer is accepted that cycle. `clear_req` during CLEAR is ignored.
- Reset asserted mid-sweep or mid-transfer: all state is cleared asynchronously, and the sweep restarts from register 0 after release.

## Timing
- Reset values: `Write`=0, `Write_Reg`=0, `Write_Data`=0, `ready0`=`ready1`=0, `init_done`=0, `last`=1 (requester 0 wins the first tie), `cnt`=0.
- Sweep:
  - Edge 1 after reset release registers `Write_Reg`=0 … edge 32 registers `Write_Reg`=31.
  - `init_done` rises on edge 32.
  - The first RUN transfer can be accepted in the cycle after edge 32 and appears on the write port one edge later.
- Write latency: valid&ready at cycle N gives the write port driven during cycle N+1, so the register file commits at the end of N+1.
- Throughput: one write per cycle. Both requesters continuously valid alternate 0,1,0,1…
- `valid`/`addr`/`data` must be held stable until ready; a requester may drop valid without a transfer.

## Structure
- Shared package `regfile_pkg`: `WORD_LENGTH`, `NBITS`, CeilLog2 function, CLEAR/RUN state encoding (1 bit).
- Sub-module `rr_arbiter_2`: two request inputs, `last` pointer register, one-hot grant output, and an `advance` input for pointer update.
- Top level holds the FSM, the sweep counter, the write-port output registers and the addr-0 suppression.

## Test plan
- Reset release, no requests → `Write`=1 with `Write_Reg`=0..31 and `Write_Data`=0 on 32 consecutive edges; `init_done`=1 on edge 32; `ready0`/`ready1`=0 throughout.
- RUN, `valid0`=`valid1`=1 held 4 cycles, requester 0 at addr 5/data 0xFEFEFEFE and requester 1 at addr 4/data 0xABABABAB, each requester dropping valid after its second accepted transfer → accepted order is 0,1,0,1; write port shows (5,FEFEFEFE),(4,ABABABAB),(5,FEFEFEFE),(4,ABABABAB) one cycle after each accept.
- `valid1`=1 only, addr 0, data 0x12345678 → `ready1`=1, `Write` stays 0; next tie with both valid grants requester 0.
- `clear_req` pulse while `valid0`=1 → `ready0`=0 that cycle, `init_done`=0 next edge, full 32-write sweep, then the pending request is accepted.
- Reset asserted at sweep index 17 for 1 cycle → outputs go to reset values immediately; the sweep restarts at `Write_Reg`=0 and completes all 32 writes.
